simplerisc_interlock_unit: RTL and testbench
============================================

# simplerisc_interlock_unit

Pipeline interlock and stall controller for the SimpleRISC 5-stage pipeline (IF, OF, EX, MA, RW). It covers the hazards that forwarding cannot resolve:
- load-use dependencies between EX and OF;
- multi-cycle mul/div/mod occupancy of EX;
- taken-branch flushes.

It drives hold and bubble controls for the IF/OF, OF/EX and EX/MA pipeline registers, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MUL_LAT, 3: EX cycles for mul (≥1).
- DIV_LAT, 8: EX cycles for div and mod (≥1).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- instruction_of  input  32  instruction currently in OF.
- instruction_e  input  32  instruction currently in EX.
- branch_taken_e  input  1  branch in EX resolved taken this cycle.
- stall_if  output  1  hold the PC.
- stall_of  output  1  hold the IF/OF register.
- bubble_e  output  1  load nop (0x68000000) into OF/EX instead of the OF instruction.
- stall_e  output  1  hold the OF/EX register (EX instruction stays).
- bubble_m  output  1  load nop into EX/MA.
- flush_of  output  1  replace IF/OF and OF/EX contents with nop.
- stall_cycles  output  16  saturating count of cycles with stall_if=1.

## Operation
Field layout:
- opcode [31:27], imm [26], rd [25:22], rs1 [21:18], rs2 [17:14].

Opcodes used:
- mul 00010, div 00011, mod 00100.
- not 01000, mov 01001, nop 01101.
- ld 01110, st 01111.
- b 10010, call 10011, ret 10100.

OF source decode:
- rs1 is read by every opcode except not, mov, nop, b, call and ret.
- rs2 is read only when imm=0, and only by opcodes 00000–01100 excluding not and mov.
- ret reads r15.
- st reads rs1 as its address register; its data register (rd) is not a load-use source.
- No register is hardwired to zero.

Load-use:
- Condition: opcode_e==ld and an OF source equals rd_e.
- Response: stall_if=stall_of=bubble_e=1 for exactly one cycle.
- After the bubble the ld sits in MA and the consumer moves to EX one cycle later; the RW→EX forward covers it.
- st in OF whose data register equals the ld rd does not stall; the RW→MA forward covers it.

Branch:
- branch_taken_e=1 → flush_of=1 in that cycle.
- Flush suppresses load-use outputs in the same cycle.

Multi-cycle FSM, states IDLE, MC_BUSY, MC_DONE:
- LAT = MUL_LAT for mul, DIV_LAT for div/mod.
- IDLE → MC_BUSY: when opcode_e is mul/div/mod and LAT>1. Load the counter with LAT-2.
- MC_BUSY: decrement the counter each cycle. At 0, go to MC_DONE.
- MC_DONE: release all stall outputs for one cycle and suppress re-detection of the same EX instruction. Return to IDLE.
- LAT==1: stay in IDLE; no stall.
- Stall outputs are asserted in the detecting IDLE cycle and in every MC_BUSY cycle: stall_if=stall_of=stall_e=bubble_m=1, bubble_e=0.

Stall counter:
- Increments each cycle stall_if=1.
- Holds at 0xFFFF.

Reset:
- While rst=1, every output is 0, the FSM is in IDLE, and the counter and stall_cycles are 0.
- Reset asserted mid-MC_BUSY aborts the operation immediately.

## Timing
- Load-use, flush and stall outputs are combinational from instruction_of, instruction_e, branch_taken_e and the registered FSM state, all in the same cycle.
- Multi-cycle op entering EX at cycle N:
  - Stall outputs high in cycles N…N+LAT-2 (LAT-1 cycles).
  - Cycle N+LAT-1 is MC_DONE, outputs low; the op leaves EX at the end of that cycle.
- Back-to-back mul: the second mul reaches EX at N+LAT while the FSM is back in IDLE, so it is detected normally.
- stall_cycles updates one cycle after the stalled cycle (registered).

## Configuration
SIMPLERISC_MULTICYCLE_ALU_EN
- Defined: the FSM, counter and MUL_LAT/DIV_LAT behaviour are compiled in.
- Undefined: mul/div/mod are single-cycle. The FSM and counter are removed; stall_e=bubble_m=0 constantly. Load-use, flush and stall_cycles are unchanged.

## Test plan
- Load-use: instruction_e=ld r3 (0x70C40000), instruction_of=add r4,r3,r2 → stall_if=stall_of=bubble_e=1 for one cycle; stall_cycles 0→1.
- Store after load: ld r3 in EX, st r3,[r1] in OF → no stall outputs asserted; stall_cycles stays 0.
- mul with MUL_LAT=3, instruction_e held at mul → stall_e/bubble_m high 2 cycles, low in the 3rd; states IDLE→MC_BUSY→MC_DONE→IDLE.
- branch_taken_e=1 with ld r5 in EX… replaced by b in EX and add r5 in OF → flush_of=1, bubble_e=0.
- Reset mid-div (DIV_LAT=8): assert rst at the 4th stall cycle → all outputs 0 immediately; after release, a fresh div stalls the full 7 cycles.
- Saturation: force 70000 stall cycles → stall_cycles=0xFFFF and holds.

Source files
------------

// File: rtl/simplerisc_interlock_unit.sv
// SimpleRISC interlock: load-use stall, branch flush, multi-cycle EX hold.
// Build macro SIMPLERISC_MULTICYCLE_ALU_EN enables the mul/div/mod FSM.
module simplerisc_interlock_unit #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_of,
  input  logic [31:0] instruction_e,
  input  logic        branch_taken_e,
  output logic        stall_if,
  output logic        stall_of,
  output logic        bubble_e,
  output logic        stall_e,
  output logic        bubble_m,
  output logic        flush_of,
  output logic [15:0] stall_cycles
);

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  logic [4:0] op_of;
  logic [4:0] op_e;
  logic       imm_of;
  logic [3:0] rs1_of;
  logic [3:0] rs2_of;
  logic [3:0] rd_e;
  logic       rs1_used;
  logic       rs2_used;
  logic       ret_of;
  logic       load_use;
  logic       lu;
  logic       mc_stall;

  assign op_of  = instruction_of[31:27];
  assign imm_of = instruction_of[26];
  assign rs1_of = instruction_of[21:18];
  assign rs2_of = instruction_of[17:14];
  assign op_e   = instruction_e[31:27];
  assign rd_e   = instruction_e[25:22];

  assign rs1_used = !(op_of inside {OP_NOT, OP_MOV, OP_NOP,
                                    OP_B, OP_CALL, OP_RET});
  assign rs2_used = !imm_of && (op_of <= 5'b01100) &&
                    !(op_of inside {OP_NOT, OP_MOV});
  assign ret_of   = (op_of == OP_RET);

  // st's data register is excluded because it is never decoded as rs1/rs2.
  assign load_use = (op_e == OP_LD) &&
                    ((rs1_used && rs1_of == rd_e) ||
                     (rs2_used && rs2_of == rd_e) ||
                     (ret_of && rd_e == 4'd15));

  assign lu       = load_use && !branch_taken_e && !rst;
  assign flush_of = branch_taken_e && !rst;
  assign stall_if = lu || mc_stall;
  assign stall_of = lu || mc_stall;
  assign bubble_e = lu;
  assign stall_e  = mc_stall;
  assign bubble_m = mc_stall;

`ifdef SIMPLERISC_MULTICYCLE_ALU_EN
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [15:0] lat;
  logic        mc_op;
  logic        fsm_stall;

  assign mc_op = op_e inside {OP_MUL, OP_DIV, OP_MOD};
  assign lat   = (op_e == OP_MUL) ? 16'(MUL_LAT) : 16'(DIV_LAT);

  // The detecting IDLE cycle is the first stall cycle, so BUSY lasts LAT-2.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fsm_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (mc_op && lat > 16'd1) begin
          fsm_stall = 1'b1;
          cnt_n     = lat - 16'd2;
          state_n   = (lat == 16'd2) ? MC_DONE : MC_BUSY;
        end
      end
      MC_BUSY: begin
        fsm_stall = 1'b1;
        cnt_n     = cnt - 16'd1;
        if (cnt_n == 16'd0) state_n = MC_DONE;
      end
      MC_DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign mc_stall = fsm_stall && !rst;

  logic unused_bits;
  assign unused_bits = ^{instruction_of[25:22], instruction_of[13:0],
                         instruction_e[26], instruction_e[21:0]};
`else
  assign mc_stall = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{instruction_of[25:22], instruction_of[13:0],
                         instruction_e[26], instruction_e[21:0],
                         MUL_LAT[0], DIV_LAT[0], OP_MUL, OP_DIV, OP_MOD};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_if && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_simplerisc_interlock_unit.sv
// Directed bench for simplerisc_interlock_unit with an expected-value queue.
module tb_simplerisc_interlock_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_of;
  logic [31:0] instruction_e;
  logic        branch_taken_e;
  logic        stall_if, stall_of, bubble_e, stall_e, bubble_m, flush_of;
  logic [15:0] stall_cycles;

  simplerisc_interlock_unit #(.MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst),
    .instruction_of(instruction_of), .instruction_e(instruction_e),
    .branch_taken_e(branch_taken_e),
    .stall_if(stall_if), .stall_of(stall_of), .bubble_e(bubble_e),
    .stall_e(stall_e), .bubble_m(bubble_m), .flush_of(flush_of),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP      = 32'h6800_0000;
  localparam logic [31:0] LD_R3    = 32'h70C4_0000;
  localparam logic [31:0] LD_R5    = 32'h7140_0000;
  localparam logic [31:0] LD_R15   = 32'h73C0_0000;
  localparam logic [31:0] ADD_R3A  = 32'h010C_8000;
  localparam logic [31:0] ADD_R3B  = 32'h0104_C000;
  localparam logic [31:0] ADDI_R3  = 32'h0504_C000;
  localparam logic [31:0] MOV_R3   = 32'h480C_0000;
  localparam logic [31:0] ST_DATA3 = 32'h78C4_0000;
  localparam logic [31:0] ST_ADDR3 = 32'h794C_0000;
  localparam logic [31:0] RET      = 32'hA000_0000;
  localparam logic [31:0] ADD_R5   = 32'h0194_0000;
  localparam logic [31:0] BR       = 32'h9000_0000;
  localparam logic [31:0] MUL      = 32'h1048_C000;
  localparam logic [31:0] DIV      = 32'h1848_C000;
  localparam logic [31:0] MODI     = 32'h2048_C000;

  // {stall_if, stall_of, bubble_e, stall_e, bubble_m, flush_of}
  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] LU = 6'b111000;
  localparam logic [5:0] FL = 6'b000001;
`ifdef SIMPLERISC_MULTICYCLE_ALU_EN
  localparam logic [5:0] MC = 6'b110110;
`else
  localparam logic [5:0] MC = 6'b000000;
`endif

  typedef struct packed {
    logic [5:0]  outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    checks += 2;
    assert ({stall_if, stall_of, bubble_e, stall_e, bubble_m, flush_of}
            === e.outs)
    else begin
      failures++;
      $error("FAIL %s outs observed=%b expected=%b", tag,
             {stall_if, stall_of, bubble_e, stall_e, bubble_m, flush_of},
             e.outs);
    end
    assert (stall_cycles === e.cnt)
    else begin
      failures++;
      $error("FAIL %s stall_cycles observed=%h expected=%h", tag,
             stall_cycles, e.cnt);
    end
  endtask

  // Drive one cycle, check mid-cycle, then advance the counter model.
  task automatic step(input string tag, input logic [31:0] of,
                      input logic [31:0] e, input logic br,
                      input logic [5:0] exp);
    instruction_of = of;
    instruction_e  = e;
    branch_taken_e = br;
    q.push_back('{outs: exp, cnt: exp_cnt});
    #2;
    chk(tag);
    @(posedge clk);
    #1;
    if (exp[5] && !rst && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  initial begin
    int total;
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    step("reset_lu", ADD_R3A, LD_R3, 1'b0, Z);
    step("reset_br", ADD_R5, BR, 1'b1, Z);
    rst = 1'b0;

    step("lu_rs1", ADD_R3A, LD_R3, 1'b0, LU);
    step("after_lu", NOP, NOP, 1'b0, Z);
    step("lu_rs2", ADD_R3B, LD_R3, 1'b0, LU);
    step("imm_no_rs2", ADDI_R3, LD_R3, 1'b0, Z);
    step("mov_no_src", MOV_R3, LD_R3, 1'b0, Z);
    step("st_data", ST_DATA3, LD_R3, 1'b0, Z);
    step("st_addr", ST_ADDR3, LD_R3, 1'b0, LU);
    step("ret_r15", RET, LD_R15, 1'b0, LU);
    step("ret_r3", RET, LD_R3, 1'b0, Z);
    step("flush_ld", ADD_R5, LD_R5, 1'b1, FL);
    step("flush_b", ADD_R5, BR, 1'b1, FL);
    step("b_not_taken", ADD_R5, BR, 1'b0, Z);

    step("mul_1", NOP, MUL, 1'b0, MC);
    step("mul_2", NOP, MUL, 1'b0, MC);
    step("mul_done", NOP, MUL, 1'b0, Z);
    step("mul2_1", NOP, MUL, 1'b0, MC);
    step("mul2_2", NOP, MUL, 1'b0, MC);
    step("mul2_done", NOP, MUL, 1'b0, Z);
    step("idle", NOP, NOP, 1'b0, Z);

    for (int i = 0; i < 7; i++) step("mod_stall", NOP, MODI, 1'b0, MC);
    step("mod_done", NOP, MODI, 1'b0, Z);

    for (int i = 0; i < 3; i++) step("div_pre", NOP, DIV, 1'b0, MC);
    rst     = 1'b1;
    exp_cnt = 16'd0;
    step("div_rst", NOP, DIV, 1'b0, Z);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step("div_stall", NOP, DIV, 1'b0, MC);
    step("div_done", NOP, DIV, 1'b0, Z);
    step("div_idle", NOP, NOP, 1'b0, Z);

    instruction_of = ADD_R3A;
    instruction_e  = LD_R3;
    branch_taken_e = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    total   = int'(exp_cnt) + 70000;
    exp_cnt = (total > 65535) ? 16'hFFFF : 16'(total);
    step("sat", ADD_R3A, LD_R3, 1'b0, LU);
    step("sat_hold", NOP, NOP, 1'b0, Z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
